// File: rtl/lift_seq.sv
// Block sequencer for the lifting core: reads one word per 4-cycle slot from
// the left/sample/right RAMs, strobes the core, and writes its result back.
module lift_seq #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic                clk_fast,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W-1:0]   res_base,
    input  logic [ADDR_W:0]     count,
    input  logic [ADDR_W-1:0]   flgs_addr,
    output logic [ADDR_W-1:0]   addr_lf,
    output logic [ADDR_W-1:0]   addr_sa,
    output logic [ADDR_W-1:0]   addr_rt,
    input  logic [143:0]        dout_lf,
    input  logic [143:0]        dout_sa,
    input  logic [143:0]        dout_rt,
    output logic [ADDR_W-1:0]   addr_flgs,
    input  logic [79:0]         dout_flgs,
    output logic [143:0]        left_s_i,
    output logic [143:0]        sam_s_i,
    output logic [143:0]        right_s_i,
    output logic [79:0]         flgs_s_i,
    output logic                update_s,
    input  logic signed [9:0]   res_out_x,
    input  logic                noupdate_s,
    output logic [9:0]          din_res,
    output logic [ADDR_W-1:0]   addr_res,
    output logic                we_res,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     skip_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        LAT,
        UPD,
        WR,
        DONE
    } state_t;

    localparam logic [ADDR_W:0] SKIP_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_CNT  = {{ADDR_W{1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_next;

    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_res;
    logic [ADDR_W:0]     r_count;
    logic [ADDR_W-1:0]   r_flgs;
    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W:0]     r_skip;
    logic [143:0]        r_left;
    logic [143:0]        r_sam;
    logic [143:0]        r_right;
    logic [79:0]         r_flgs_op;

    logic                w_accept;
    logic                w_go;
    logic                w_last;
    logic                w_upd;
    logic                w_we;
    logic                w_skip;
    logic                w_busy;
    logic                w_done;

    assign w_last = ({1'b0, r_idx} == (r_count - ONE_CNT));

    always_ff @(posedge clk_fast) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_go     = 1'b0;
        w_upd    = 1'b0;
        w_we     = 1'b0;
        w_skip   = 1'b0;
        w_busy   = 1'b1;
        w_done   = 1'b0;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    w_accept = 1'b1;
                    if (count != '0) begin
                        w_go   = 1'b1;
                        w_next = RD;
                    end else begin
                        w_next = DONE;
                    end
                end
            end
            RD:  w_next = LAT;
            LAT: w_next = UPD;
            UPD: begin
                w_upd  = 1'b1;
                w_next = WR;
            end
            WR: begin
                w_we   = ~noupdate_s;
                w_skip = noupdate_s;
                w_next = w_last ? DONE : RD;
            end
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Block parameters are only latched for a non-empty block, so a count=0
    // request leaves the RAM address outputs untouched.
    always_ff @(posedge clk_fast) begin
        if (rst) begin
            r_base    <= '0;
            r_res     <= '0;
            r_count   <= '0;
            r_flgs    <= '0;
            r_idx     <= '0;
            r_skip    <= '0;
            r_left    <= '0;
            r_sam     <= '0;
            r_right   <= '0;
            r_flgs_op <= '0;
        end else begin
            if (w_accept) begin
                r_skip <= '0;
            end
            if (w_go) begin
                r_base  <= base_addr;
                r_res   <= res_base;
                r_count <= count;
                r_flgs  <= flgs_addr;
                r_idx   <= '0;
            end
            if (r_state == LAT) begin
                r_left    <= dout_lf;
                r_sam     <= dout_sa;
                r_right   <= dout_rt;
                r_flgs_op <= dout_flgs;
            end
            if (w_skip && (r_skip != SKIP_MAX)) begin
                r_skip <= r_skip + ONE_CNT;
            end
            if ((r_state == WR) && !w_last) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Address sums are ADDR_W wide, so wrap-around is implicit.
    assign addr_lf   = r_base + r_idx;
    assign addr_sa   = r_base + r_idx;
    assign addr_rt   = r_base + r_idx;
    assign addr_flgs = r_flgs;
    assign addr_res  = r_res + r_idx;

    assign left_s_i  = r_left;
    assign sam_s_i   = r_sam;
    assign right_s_i = r_right;
    assign flgs_s_i  = r_flgs_op;

    assign update_s  = w_upd;
    assign we_res    = w_we;
    assign din_res   = w_we ? $unsigned(res_out_x) : '0;
    assign busy      = w_busy;
    assign done      = w_done;
    assign skip_cnt  = r_skip;

endmodule
